// File: rtl/rc_charge_discharge_cv.sv
// rc_charge_discharge_cv: RC capacitor control-voltage source for the 555 VCO.
// Each accepted audio_clk_en strobe moves v_control one exponential step
// toward V_HIGH (trigger=1, charge through R_CHARGE) or V_LOW (trigger=0,
// discharge through R_DISCHARGE). The step goes through a 3-stage pipeline.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   audio_clk_en one-cycle sample strobe (spacing >= 4 clk)
//   trigger      1 = charge, 0 = discharge; sampled on audio_clk_en only
//   v_control    signed capacitor voltage, V_LOW..V_HIGH
//   charging     registered: state is CHARGE
//   settled      registered: state is IDLE or FULL
module rc_charge_discharge_cv #(
  parameter int unsigned CLOCK_RATE   = 50000000,
  parameter int unsigned SAMPLE_RATE  = 48000,
  parameter int unsigned R_CHARGE     = 47000,
  parameter int unsigned R_DISCHARGE  = 100000,
  parameter int unsigned C_35_SHIFTED = 1134,
  parameter int          V_HIGH       = 24000,
  parameter int          V_LOW        = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               audio_clk_en,
  input  logic               trigger,
  output logic signed [15:0] v_control,
  output logic               charging,
  output logic               settled
);

  // Step coefficients: 2^51 / (fs * R * C*2^35), saturated to 1..65535
  localparam longint unsigned DEN_C = 64'(SAMPLE_RATE) * 64'(R_CHARGE) * 64'(C_35_SHIFTED);
  localparam longint unsigned DEN_D = 64'(SAMPLE_RATE) * 64'(R_DISCHARGE) * 64'(C_35_SHIFTED);
  localparam longint unsigned RAW_C = (64'd1 << 51) / DEN_C;
  localparam longint unsigned RAW_D = (64'd1 << 51) / DEN_D;
  localparam logic [15:0] ALPHA_C = (RAW_C > 64'd65535) ? 16'hffff :
                                    (RAW_C < 64'd1) ? 16'd1 : 16'(RAW_C);
  localparam logic [15:0] ALPHA_D = (RAW_D > 64'd65535) ? 16'hffff :
                                    (RAW_D < 64'd1) ? 16'd1 : 16'(RAW_D);

  localparam logic signed [15:0] VH16 = 16'(V_HIGH);
  localparam logic signed [15:0] VL16 = 16'(V_LOW);
  localparam logic signed [18:0] VH19 = 19'(V_HIGH);
  localparam logic signed [18:0] VL19 = 19'(V_LOW);

  // Elaboration-time sanity checks on the parameter set
  if (64'(CLOCK_RATE) < 64'(SAMPLE_RATE) * 64'd4) begin : g_bad_rate
    $error("CLOCK_RATE must be at least 4x SAMPLE_RATE");
  end
  if (V_HIGH >= 32767 || V_LOW < 0 || V_LOW >= V_HIGH) begin : g_bad_volt
    $error("require 0 <= V_LOW < V_HIGH < 32767");
  end

  typedef enum logic [1:0] {IDLE, CHARGE, FULL, DISCHARGE} state_t;

  state_t state;
  state_t nxt;

  logic               s1_valid;
  logic signed [16:0] s1_diff;
  logic        [15:0] s1_alpha;
  logic               s2_valid;
  logic signed [16:0] s2_diff;
  logic signed [33:0] s2_prod;

  logic               accept;
  logic               issue;
  logic signed [16:0] target;
  logic        [15:0] alpha;
  logic signed [16:0] diff;
  logic signed [17:0] step_raw;
  logic signed [17:0] step;
  logic signed [18:0] sum;
  logic signed [15:0] v_new;

  // Next state for a strobe; target/alpha follow the next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (trigger)  nxt = CHARGE;
      CHARGE:    if (!trigger) nxt = DISCHARGE;
      FULL:      if (!trigger) nxt = DISCHARGE;
      DISCHARGE: if (trigger)  nxt = CHARGE;
      default:   nxt = IDLE;
    endcase
    // strobes landing while the pipeline is busy are dropped entirely
    accept = audio_clk_en && !s1_valid && !s2_valid;
    issue  = (nxt == CHARGE) || (nxt == DISCHARGE);
    target = (nxt == CHARGE) ? 17'(V_HIGH) : 17'(V_LOW);
    alpha  = (nxt == CHARGE) ? ALPHA_C : ALPHA_D;
    diff   = target - {v_control[15], v_control};
  end

  // Stage 3: floor shift, minimum one-LSB step toward target, clamp
  always_comb begin
    step_raw = 18'(s2_prod >>> 16);
    step     = step_raw;
    if (step_raw == 18'sd0 && s2_diff != 17'sd0) begin
      step = s2_diff[16] ? -18'sd1 : 18'sd1;
    end
    sum = 19'(v_control) + 19'(step);
    if (sum > VH19) begin
      v_new = VH16;
    end else if (sum < VL19) begin
      v_new = VL16;
    end else begin
      v_new = 16'(sum);
    end
  end

  // FSM, pipeline registers and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      v_control <= VL16;
      s1_valid  <= 1'b0;
      s1_diff   <= '0;
      s1_alpha  <= '0;
      s2_valid  <= 1'b0;
      s2_diff   <= '0;
      s2_prod   <= '0;
      charging  <= 1'b0;
      settled   <= 1'b1;
    end else begin
      charging <= (state == CHARGE);
      settled  <= (state == IDLE) || (state == FULL);

      s1_valid <= accept && issue;
      if (accept) begin
        state    <= nxt;
        s1_diff  <= diff;
        s1_alpha <= alpha;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_diff <= s1_diff;
        s2_prod <= s1_diff * $signed({1'b0, s1_alpha});
      end

      // accept is never true with s2_valid, so these writes cannot collide
      if (s2_valid) begin
        v_control <= v_new;
        if (state == CHARGE && v_new == VH16) begin
          state <= FULL;
        end else if (state == DISCHARGE && v_new == VL16) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_rc_charge_discharge_cv.sv
// Scoreboard bench for rc_charge_discharge_cv: stimulus pushes expected
// values tagged with the clock count at which they must hold; a monitor
// pops and compares them on the falling edge.
module tb_rc_charge_discharge_cv;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               audio_clk_en = 1'b0;
  logic               trigger = 1'b0;
  logic signed [15:0] v_control;
  logic               charging;
  logic               settled;

  rc_charge_discharge_cv dut (
    .clk          (clk),
    .reset        (reset),
    .audio_clk_en (audio_clk_en),
    .trigger      (trigger),
    .v_control    (v_control),
    .charging     (charging),
    .settled      (settled)
  );

  always #5 clk = ~clk;

  // posedge counter; expectations are keyed to it
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // -1 in a field means "do not check"
  typedef struct {
    int    cyc;
    int    v;
    int    chg;
    int    stl;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input int c, input int v, input int chg, input int stl, input string nm);
    exp_t e;
    e.cyc = c; e.v = v; e.chg = chg; e.stl = stl; e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due at this clock count
  exp_t em;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      em = sb.pop_front();
      if (em.cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", em.nm, em.cyc, cyc);
      end else begin
        if (em.v >= 0) begin
          n_cmp++;
          if (int'(v_control) != em.v) begin
            n_bad++;
            $display("FAIL %s v_control @%0d: got %0d want %0d", em.nm, cyc, v_control, em.v);
          end
        end
        if (em.chg >= 0) begin
          n_cmp++;
          if (int'(charging) != em.chg) begin
            n_bad++;
            $display("FAIL %s charging @%0d: got %0d want %0d", em.nm, cyc, charging, em.chg);
          end
        end
        if (em.stl >= 0) begin
          n_cmp++;
          if (int'(settled) != em.stl) begin
            n_bad++;
            $display("FAIL %s settled @%0d: got %0d want %0d", em.nm, cyc, settled, em.stl);
          end
        end
      end
    end
  end

  // Reference step from the behavioural description (V_LOW=0, V_HIGH=24000)
  function automatic int model_step(input int v, input int target, input int alpha);
    longint d, p, s, r;
    d = longint'(target) - longint'(v);
    p = d * longint'(alpha);
    s = p >>> 16;
    if (s == 0 && d != 0) s = (d > 0) ? 64'sd1 : -64'sd1;
    r = longint'(v) + s;
    if (r > 24000) r = 24000;
    if (r < 0) r = 0;
    return int'(r);
  endfunction

  // One strobe; pre_v/flags checked 2 clk later, new_v 3 clk later, next strobe 4 clk on
  task automatic strobe(input bit trig, input int pre_v, input int new_v,
                        input int chg, input int stl, input string nm);
    int n;
    @(negedge clk);
    n = cyc;
    push(n + 2, pre_v, chg, stl, nm);
    push(n + 3, new_v, -1, -1, nm);
    audio_clk_en = 1'b1;
    trigger      = trig;
    @(negedge clk);
    audio_clk_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int v, nv, n;

    // reset state
    repeat (3) @(negedge clk);
    n = cyc;
    push(n + 1, 0, 0, 1, "reset_state");
    @(negedge clk);
    reset = 1'b0;

    // 1: idle discharge strobes do nothing
    for (int i = 0; i < 10; i++) strobe(1'b0, 0, 0, 0, 1, "t1_idle");

    // 2: first two charge steps, hand-computed
    strobe(1'b1, 0, 322, 1, 0, "t2_first");
    strobe(1'b1, 322, 639, 1, 0, "t2_second");

    // 3: ramp to V_HIGH
    v = 639;
    for (int i = 0; i < 3000 && v != 24000; i++) begin
      nv = model_step(v, 24000, 880);
      strobe(1'b1, v, nv, 1, 0, "t3_ramp");
      v = nv;
    end
    for (int i = 0; i < 3; i++) strobe(1'b1, 24000, 24000, 0, 1, "t3_full");

    // 4: discharge from FULL to V_LOW
    strobe(1'b0, 24000, 23848, 0, 0, "t4_first");
    v = 23848;
    for (int i = 0; i < 3000 && v != 0; i++) begin
      nv = model_step(v, 0, 413);
      strobe(1'b0, v, nv, 0, 0, "t4_ramp");
      v = nv;
    end
    for (int i = 0; i < 3; i++) strobe(1'b0, 0, 0, 0, 1, "t4_idle");

    // 5: second strobe 2 clk later (trigger=0) must be ignored
    @(negedge clk);
    n = cyc;
    push(n + 2, 0, 1, 0, "t5_pre");
    push(n + 3, 322, 1, 0, "t5_step");
    push(n + 4, 322, 1, 0, "t5_flags");
    push(n + 5, 322, 1, 0, "t5_no_second");
    push(n + 7, 322, 1, 0, "t5_late");
    audio_clk_en = 1'b1; trigger = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    @(negedge clk);
    audio_clk_en = 1'b1; trigger = 1'b0;
    @(negedge clk);
    audio_clk_en = 1'b0;
    repeat (6) @(negedge clk);

    // mid-ramp reversal continues from current v
    strobe(1'b0, 322, 319, 0, 0, "rev_discharge");

    // 6: reset during S2 of a charge step
    @(negedge clk);
    n = cyc;
    push(n + 1, 0, 0, 1, "t6_async");
    push(n + 2, 0, 0, 1, "t6_held");
    push(n + 3, 0, 0, 1, "t6_no_s3");
    push(n + 5, 0, 0, 1, "t6_after");
    audio_clk_en = 1'b1; trigger = 1'b1;
    @(posedge clk);
    #1;
    audio_clk_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    while (sb.size() > 0) begin
      em = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s: expectation for cycle %0d never checked", em.nm, em.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
